adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter WIDTH, default 256, SHALL set operand/sum width in bits.
REQ-002 Parameter TIMEOUT, default 64, SHALL set the WAIT-state watchdog limit in cycles (used only with ADD_ARB_TIMEOUT_EN).
REQ-003 clk  in  1  SHALL be the single clock; all logic on rising edge.
REQ-004 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 reqN_valid  in  1  (N=0,1) SHALL flag that requester N presents operands.
REQ-006 reqN_ready  out  1  SHALL flag operand acceptance from requester N.
REQ-007 reqN_a, reqN_b  in  WIDTH  SHALL be requester N operands.
REQ-008 rspN_valid  out  1  SHALL flag a result for requester N.
REQ-009 rspN_ready  in  1  SHALL flag requester N consumes the result.
REQ-010 rspN_sum  out  WIDTH  SHALL carry requester N's result.
REQ-011 rspN_err  out  1  SHALL flag a timed-out operation.
REQ-012 add_start, add_rst  out  1  SHALL drive the shared serial adder's start and active-high reset.
REQ-013 add_a, add_b  out  WIDTH  SHALL be registered operands to the adder.
REQ-014 add_sum  in  WIDTH, add_done  in  1  SHALL be the adder's result and completion flag.
REQ-015 busy  out  1  SHALL be high whenever state is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, START, WAIT, RESP, encoded in 2 bits.
REQ-017 IDLE: add_rst=1, add_start=0; if any reqN_valid, grant one, go START.
REQ-018 Arbitration: single valid wins; both valid -> requester not granted last (round-robin); last_grant resets to 1 so req0 wins first tie.
REQ-019 reqN_ready SHALL be high only in IDLE, only for the granted N, for exactly that cycle; add_a/add_b and owner latched on that edge.
REQ-020 START: add_rst=0, add_start=1 for exactly one cycle, then WAIT.
REQ-021 WAIT: add_rst=0, add_start=0; on add_done=1 latch add_sum into result register, go RESP.
REQ-022 add_done SHALL be ignored in every state except WAIT (stale done cleared by add_rst in IDLE).
REQ-023 RESP: rspN_valid=1 for owner only; sum/err held stable until rspN_ready=1, then IDLE next cycle.
REQ-024 Non-owner rsp valid SHALL stay 0; requests arriving while busy SHALL see ready=0 and wait.
REQ-025 Latency: grant edge T -> START cycle T+1 -> rsp valid first cycle after add_done sampled high in WAIT (T+11 with the 8-word adder).
REQ-026 Back-to-back: request valid in cycle IDLE is re-entered SHALL be granted that same cycle.

Reset
REQ-027 On rst: state=IDLE, last_grant=1, all ready/valid/err=0, add_start=0, add_rst=1, result and add_a/add_b=0.
REQ-028 rst mid-operation SHALL discard the in-flight operation with no response issued.

Configuration
REQ-029 Macro ADD_ARB_TIMEOUT_EN defined: WAIT counts cycles from 0; reaching TIMEOUT-1 without add_done -> RESP with rspN_err=1, rspN_sum=0; counter clears on WAIT entry.
REQ-030 Macro undefined: no counter; rspN_err tied 0; WAIT waits indefinitely for add_done.

Verification
REQ-031 req0 only, a=256'h1111...1111, b=0 -> one req0_ready pulse, one add_start pulse, rsp0_sum=a, rsp0_err=0.
REQ-032 req0 and req1 valid same cycle from reset -> req0 served first, req1 next; third tie -> req0 again (alternation).
REQ-033 rsp0_ready held low 5 cycles in RESP -> rsp0_valid and sum stable 5 cycles, req1_ready stays 0, busy=1.
REQ-034 rst asserted 3 cycles after add_start -> next cycle IDLE, add_rst=1, no rsp valid; next request completes normally.
REQ-035 Timeout build, TIMEOUT=16, add_done never asserted -> rsp0_valid with rsp0_err=1, sum=0, exactly 16 cycles after WAIT entry.
REQ-036 add_done forced high in IDLE and START -> ignored; result taken only from WAIT sample.

Source files
------------

// File: rtl/adder_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle serial adder.
// Optional WAIT-state watchdog is compiled in when ADD_ARB_TIMEOUT_EN is defined.
module adder_arbiter #(
   parameter int WIDTH   = 256,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_sum,
   output logic             rsp0_err,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_sum,
   output logic             rsp1_err,
   output logic             add_start,
   output logic             add_rst,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   input  logic [WIDTH-1:0] add_sum,
   input  logic             add_done,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t           state;
   logic             last_grant;
   logic             owner;
   logic             grant_any;
   logic             grant_sel;
   logic             owner_ready;
   logic [WIDTH-1:0] result;

   if (TIMEOUT < 1) begin : g_timeout_check
      $error("adder_arbiter: TIMEOUT must be at least 1");
   end

   // On a tie the requester that was not served last wins.
   always_comb begin
      grant_any = req0_valid | req1_valid;
      grant_sel = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
   end

   assign req0_ready  = ~rst & (state == S_IDLE) & grant_any & ~grant_sel;
   assign req1_ready  = ~rst & (state == S_IDLE) & grant_any &  grant_sel;
   assign owner_ready = owner ? rsp1_ready : rsp0_ready;
   assign busy        = (state != S_IDLE);
   assign rsp0_sum    = result;
   assign rsp1_sum    = result;

`ifdef ADD_ARB_TIMEOUT_EN
   localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             err_q;

   assign rsp0_err = rsp0_valid & err_q;
   assign rsp1_err = rsp1_valid & err_q;
`else
   assign rsp0_err = 1'b0;
   assign rsp1_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         add_start  <= 1'b0;
         add_rst    <= 1'b1;
         add_a      <= '0;
         add_b      <= '0;
         result     <= '0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
`ifdef ADD_ARB_TIMEOUT_EN
         wait_cnt   <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_any) begin
                  owner      <= grant_sel;
                  last_grant <= grant_sel;
                  add_a      <= grant_sel ? req1_a : req0_a;
                  add_b      <= grant_sel ? req1_b : req0_b;
                  add_start  <= 1'b1;
                  add_rst    <= 1'b0;
                  state      <= S_START;
               end
            end
            S_START: begin
               add_start <= 1'b0;
`ifdef ADD_ARB_TIMEOUT_EN
               wait_cnt  <= '0;
`endif
               state     <= S_WAIT;
            end
            // add_done is only honoured here; anything seen earlier is stale.
            S_WAIT: begin
               if (add_done) begin
                  result     <= add_sum;
                  rsp0_valid <= ~owner;
                  rsp1_valid <= owner;
                  state      <= S_RESP;
`ifdef ADD_ARB_TIMEOUT_EN
                  err_q      <= 1'b0;
               end else if (wait_cnt == CNT_LAST) begin
                  result     <= '0;
                  err_q      <= 1'b1;
                  rsp0_valid <= ~owner;
                  rsp1_valid <= owner;
                  state      <= S_RESP;
               end else begin
                  wait_cnt   <= wait_cnt + 1'b1;
`endif
               end
            end
            S_RESP: begin
               if (owner_ready) begin
                  rsp0_valid <= 1'b0;
                  rsp1_valid <= 1'b0;
                  add_rst    <= 1'b1;
`ifdef ADD_ARB_TIMEOUT_EN
                  err_q      <= 1'b0;
`endif
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: behavioural serial-adder model, vector table, directed
// corner sequences and a randomized run against a transaction-level reference.
module tb_adder_arbiter;
   localparam int W  = 256;
   localparam int TO = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid, req0_ready, req1_valid, req1_ready;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
   logic [W-1:0] rsp0_sum, rsp1_sum;
   logic         add_start, add_rst, add_done, busy;
   logic [W-1:0] add_a, add_b, add_sum;

   always #5 clk = ~clk;

   adder_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_sum(rsp0_sum), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_sum(rsp1_sum), .rsp1_err(rsp1_err),
      .add_start(add_start), .add_rst(add_rst), .add_a(add_a), .add_b(add_b),
      .add_sum(add_sum), .add_done(add_done), .busy(busy)
   );

   // Serial adder stand-in: done appears add_lat+1 cycles after the start cycle.
   logic         m_done = 1'b0, m_run = 1'b0;
   int           m_cnt = 0;
   logic [W-1:0] m_sum = '0;
   int           add_lat = 8;
   logic         no_done = 1'b0, force_done = 1'b0;
   logic [W-1:0] force_sum = '0;

   always @(posedge clk) begin
      if (add_rst === 1'b1) begin
         m_done <= 1'b0; m_run <= 1'b0; m_cnt <= 0;
      end else if (add_start === 1'b1) begin
         m_run <= 1'b1; m_cnt <= 1; m_done <= 1'b0;
      end else if (m_run) begin
         if (m_cnt >= add_lat) begin
            m_done <= 1'b1; m_sum <= add_a + add_b; m_run <= 1'b0;
         end else m_cnt <= m_cnt + 1;
      end
   end
   assign add_done = force_done | (m_done & ~no_done);
   assign add_sum  = force_done ? force_sum : m_sum;

   int cyc = 0, n_start = 0, n_hs0 = 0, n_hs1 = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (add_start === 1'b1) n_start <= n_start + 1;
      if (req0_valid === 1'b1 && req0_ready === 1'b1) n_hs0 <= n_hs0 + 1;
      if (req1_valid === 1'b1 && req1_ready === 1'b1) n_hs1 <= n_hs1 + 1;
   end

   int n_checks = 0, n_fail = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chki(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic adv();
      @(posedge clk); #2;
   endtask

   function automatic logic [W-1:0] rand_w();
      logic [W-1:0] r;
      for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   task automatic wait_grant(input bit who);
      bit ok = 0;
      for (int n = 0; n < 100; n++) begin
         if ((who ? req1_ready : req0_ready) === 1'b1) begin ok = 1; break; end
         adv(); #1;
      end
      if (!ok) chki("grant_wait", 0, 1);
   endtask

   task automatic wait_rsp(input bit who);
      bit ok = 0;
      for (int n = 0; n < 300; n++) begin
         if ((who ? rsp1_valid : rsp0_valid) === 1'b1) begin ok = 1; break; end
         adv(); #1;
      end
      if (!ok) chki("rsp_wait", 0, 1);
   endtask

   task automatic consume(input bit who);
      if (who) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
      adv();
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      #1;
   endtask

   task automatic do_txn(input bit who, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] sum, output logic err, output int lat);
      int t;
      adv();
      if (who) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
      else     begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
      #1;
      wait_grant(who);
      t = cyc;
      adv();
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      wait_rsp(who);
      lat = cyc - t;
      sum = who ? rsp1_sum : rsp0_sum;
      err = who ? rsp1_err : rsp0_err;
      chki("non_owner_valid", 32'(who ? rsp0_valid : rsp1_valid), 0);
      consume(who);
      chki("idle_after_rsp", 32'({busy, rsp1_valid, rsp0_valid}), 0);
   endtask

   typedef struct {
      bit           who;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
   } vec_t;
   vec_t vt[6];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] s, ea, eb;
      logic         e, hs0, hs1, m_busy, m_owner, m_last;
      logic [1:0]   exp_rdy, rv;
      logic [W-1:0] m_exp;
      int           lat, t, seen, since, n_done, s0, h0;

      vt[0] = '{0, {8{32'h1111_1111}}, '0, {8{32'h1111_1111}}};
      vt[1] = '{1, '1, 256'd1, '0};
      vt[2] = '{0, {4{64'h8000_0000_0000_0000}}, {4{64'h8000_0000_0000_0000}},
                {64'd1, 64'd1, 64'd1, 64'd0}};
      vt[3] = '{1, {128'd0, {128{1'b1}}}, 256'd1, {127'd0, 1'b1, 128'd0}};
      vt[4] = '{0, 256'd123456789, 256'd987654321, 256'd1111111110};
      vt[5] = '{1, {8{32'hAAAA_AAAA}}, {8{32'h5555_5555}}, '1};

      rst = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      repeat (3) adv();
      #1;
      chki("rst_ready", 32'({req1_ready, req0_ready}), 0);
      chki("rst_busy", 32'(busy), 0);
      chki("rst_add_rst", 32'(add_rst), 1);
      chki("rst_add_start", 32'(add_start), 0);
      chki("rst_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 0);
      chki("rst_err", 32'({rsp1_err, rsp0_err}), 0);
      chk("rst_add_a", add_a, '0);
      chk("rst_add_b", add_b, '0);
      chk("rst_result", rsp0_sum, '0);
      req0_valid = 1'b0;
      adv(); rst = 1'b0; #1;

      // Single request, checked pulses and latency.
      s0 = n_start; h0 = n_hs0;
      do_txn(0, {8{32'h1111_1111}}, '0, s, e, lat);
      chk("single_sum", s, {8{32'h1111_1111}});
      chki("single_err", 32'(e), 0);
      chki("single_latency", lat, 11);
      chki("single_start_pulses", n_start - s0, 1);
      chki("single_ready_pulses", n_hs0 - h0, 1);

      foreach (vt[i]) begin
         do_txn(vt[i].who, vt[i].a, vt[i].b, s, e, lat);
         chk($sformatf("vec%0d_sum", i), s, vt[i].exp);
         chki($sformatf("vec%0d_err", i), 32'(e), 0);
         chki($sformatf("vec%0d_lat", i), lat, 11);
      end

      // Ties from reset alternate, loser granted on IDLE re-entry.
      adv(); rst = 1'b1; adv(); rst = 1'b0;
      req0_valid = 1'b1; req0_a = 256'd10; req0_b = 256'd5;
      req1_valid = 1'b1; req1_a = 256'd100; req1_b = 256'd50;
      #1;
      chki("tie1_grant", 32'({req1_ready, req0_ready}), 32'b01);
      adv(); req0_valid = 1'b0; #1;
      chki("tie1_busy_ready", 32'({req1_ready, req0_ready}), 0);
      wait_rsp(0);
      chk("tie1_sum0", rsp0_sum, 256'd15);
      chki("tie1_non_owner", 32'(rsp1_valid), 0);
      consume(0);
      chki("tie1_b2b_grant", 32'({req1_ready, req0_ready}), 32'b10);
      adv(); req1_valid = 1'b0; #1;
      wait_rsp(1);
      chk("tie1_sum1", rsp1_sum, 256'd150);
      consume(1);
      adv();
      req0_valid = 1'b1; req1_valid = 1'b1; #1;
      chki("tie3_grant", 32'({req1_ready, req0_ready}), 32'b01);
      adv(); req0_valid = 1'b0; #1;
      wait_rsp(0); consume(0);
      chki("tie4_grant", 32'({req1_ready, req0_ready}), 32'b10);
      adv(); req1_valid = 1'b0; #1;
      wait_rsp(1); consume(1);

      // Response held off for 5 cycles while req1 waits.
      ea = rand_w(); eb = rand_w();
      adv(); req0_valid = 1'b1; req0_a = ea; req0_b = eb; #1;
      wait_grant(0);
      adv(); req0_valid = 1'b0; req1_valid = 1'b1; req1_a = 256'd7; req1_b = 256'd8; #1;
      chki("hold_start_ready1", 32'(req1_ready), 0);
      wait_rsp(0);
      for (int i = 0; i < 5; i++) begin
         chki("hold_valid", 32'(rsp0_valid), 1);
         chk("hold_sum", rsp0_sum, ea + eb);
         chki("hold_ready1", 32'(req1_ready), 0);
         chki("hold_busy", 32'(busy), 1);
         adv(); #1;
      end
      consume(0);
      chki("hold_b2b_grant1", 32'(req1_ready), 1);
      adv(); req1_valid = 1'b0; #1;
      wait_rsp(1);
      chk("hold_sum1", rsp1_sum, 256'd15);
      consume(1);

      // Reset three cycles after add_start drops the operation.
      adv(); req0_valid = 1'b1; req0_a = 256'd1; req0_b = 256'd2; #1;
      wait_grant(0);
      adv(); req0_valid = 1'b0; #1;
      chki("midrst_start", 32'(add_start), 1);
      repeat (2) begin adv(); #1; end
      adv(); rst = 1'b1; #1;
      adv(); rst = 1'b0; #1;
      chki("midrst_busy", 32'(busy), 0);
      chki("midrst_add_rst", 32'(add_rst), 1);
      chki("midrst_rsp", 32'({rsp1_valid, rsp0_valid}), 0);
      seen = 0;
      repeat (20) begin adv(); #1; if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1) seen++; end
      chki("midrst_no_rsp", seen, 0);
      do_txn(0, 256'd40, 256'd2, s, e, lat);
      chk("midrst_next_sum", s, 256'd42);

      // Stale done in IDLE/START must be ignored.
      adv(); force_done = 1'b1; force_sum = {8{32'hDEAD_BEEF}}; #1;
      chki("stale_idle_busy", 32'(busy), 0);
      adv(); req0_valid = 1'b1; req0_a = 256'd300; req0_b = 256'd33; #1;
      wait_grant(0);
      t = cyc;
      adv(); req0_valid = 1'b0; #1;
      chki("stale_start", 32'(add_start), 1);
      adv(); force_done = 1'b0; #1;
      wait_rsp(0);
      chki("stale_latency", cyc - t, 11);
      chk("stale_sum", rsp0_sum, 256'd333);
      consume(0);

      // Adder that never finishes.
      no_done = 1'b1;
      adv(); req0_valid = 1'b1; req0_a = 256'd9; req0_b = 256'd9; #1;
      wait_grant(0);
      t = cyc;
      adv(); req0_valid = 1'b0; #1;
`ifdef ADD_ARB_TIMEOUT_EN
      wait_rsp(0);
      chki("timeout_latency", cyc - t, TO + 2);
      chki("timeout_err", 32'(rsp0_err), 1);
      chk("timeout_sum", rsp0_sum, '0);
      consume(0);
      no_done = 1'b0;
`else
      seen = 0;
      repeat (100) begin adv(); #1; if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1) seen++; end
      chki("nodone_no_rsp", seen, 0);
      chki("nodone_busy", 32'(busy), 1);
      chki("nodone_err", 32'(rsp0_err), 0);
      no_done = 1'b0;
      wait_rsp(0);
      chk("nodone_late_sum", rsp0_sum, 256'd18);
      consume(0);
`endif

      // Randomized traffic against a transaction-level model.
      adv(); rst = 1'b1; adv(); rst = 1'b0; #1;
      m_busy = 0; m_owner = 0; m_last = 1; m_exp = '0; since = 0; n_done = 0;
      for (int c = 0; c < 700; c++) begin
         exp_rdy = 2'b00;
         if (!m_busy && (req0_valid || req1_valid))
            exp_rdy = (req0_valid && req1_valid) ? (m_last ? 2'b01 : 2'b10) : {req1_valid, req0_valid};
         chki("rand_ready", 32'({req1_ready, req0_ready}), 32'(exp_rdy));
         hs0 = req0_valid & req0_ready;
         hs1 = req1_valid & req1_ready;
         rv  = {rsp1_valid, rsp0_valid};
         if (rv != 2'b00)
            chki("rand_rsp_owner", 32'(rv), m_busy ? (m_owner ? 32'b10 : 32'b01) : 32'b00);
         if (m_busy && (m_owner ? (rsp1_valid & rsp1_ready) : (rsp0_valid & rsp0_ready))) begin
            chk("rand_sum", m_owner ? rsp1_sum : rsp0_sum, m_exp);
            chki("rand_err", 32'(m_owner ? rsp1_err : rsp0_err), 0);
            m_busy = 0; n_done++;
         end else if (exp_rdy != 2'b00) begin
            m_busy = 1; m_owner = exp_rdy[1]; m_last = m_owner; since = 0;
            m_exp = m_owner ? req1_a + req1_b : req0_a + req0_b;
            add_lat = $urandom_range(1, 10);
         end
         if (m_busy) since++;
         if (since > 80) begin chki("rand_progress", 0, 1); break; end
         adv();
         if (hs0) req0_valid = (c < 600) && ($urandom_range(0, 3) == 0);
         else if (!req0_valid && c < 600 && $urandom_range(0, 2) == 0) req0_valid = 1'b1;
         if (hs0 || req0_valid && !req0_ready) begin end
         if (hs0 && req0_valid) begin req0_a = rand_w(); req0_b = rand_w(); end
         if (!hs0 && req0_valid && !m_busy && c < 600) begin end
         if (hs1) req1_valid = (c < 600) && ($urandom_range(0, 3) == 0);
         else if (!req1_valid && c < 600 && $urandom_range(0, 2) == 0) req1_valid = 1'b1;
         if (hs1 && req1_valid) begin req1_a = rand_w(); req1_b = rand_w(); end
         rsp0_ready = (c >= 600) ? 1'b1 : 1'($urandom_range(0, 1));
         rsp1_ready = (c >= 600) ? 1'b1 : 1'($urandom_range(0, 1));
         #1;
      end
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      chki("rand_drained", 32'(m_busy), 0);
      chki("rand_enough_txns", 32'(n_done > 20), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
